// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the framebuffer arbiter state type.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

  localparam int FB_ADDR_W     = 19;
  localparam int FB_DATA_W     = 8;
  localparam int FB_FIFO_DEPTH = 16;
  localparam int FB_FIFO_LOW   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vga_pixel_fifo.sv
// First-word-fall-through pixel FIFO with flush and occupancy count.
module vga_pixel_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            pop_data,
  output logic                         valid,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              do_push;
  logic              do_pop;

  // Pops on empty are ignored here; the caller tracks underflow.
  assign do_pop  = pop && (count_reg != '0) && !flush;
  assign do_push = push && ((count_reg != FULL_LVL) || do_pop) && !flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign valid    = (count_reg != '0);
  assign pop_data = valid ? mem[rd_ptr_reg] : '0;
  assign count    = count_reg;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display prefetch into a pixel FIFO plus a host req/ack port.
// Build option: define VGA_FB_HOST_READ_EN to enable host reads (otherwise every host grant is a write).
module vga_fb_arbiter #(
  parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int ADDR_W     = vga_pkg::FB_ADDR_W,
  parameter int DATA_W     = vga_pkg::FB_DATA_W,
  parameter int FIFO_DEPTH = vga_pkg::FB_FIFO_DEPTH,
  parameter int FIFO_LOW   = vga_pkg::FB_FIFO_LOW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_re,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underflow,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import vga_pkg::*;

  localparam int FRAME = H_ACTIVE * V_ACTIVE;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);
  localparam logic [CNT_W:0]    DEPTH_LVL = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  LOW_LVL   = CNT_W'(FIFO_LOW);

  arb_state_t        state_reg;
  logic [ADDR_W-1:0] fetch_addr_reg;
  logic              disp_inflight_reg;
  logic              host_ack_reg;
  logic              underflow_reg;

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    fifo_level;
  logic              eligible;
  logic              urgent;
  logic              host_ok;
  logic              grant_disp;
  logic              grant_host;
  logic              host_is_write;
  logic              fifo_push;
  logic              fifo_pop;

  // Reserve a FIFO slot for the read already in flight so a push can never overflow.
  assign fifo_level = {1'b0, fifo_count} + {{CNT_W{1'b0}}, disp_inflight_reg};
  assign eligible   = (state_reg == FETCH) && (fifo_level < DEPTH_LVL);
  assign urgent     = eligible && (fifo_count < LOW_LVL);
  // The ack cycle still counts as in flight, so a held request is served every other cycle.
  assign host_ok    = host_req && !host_ack_reg;

  // No display grant in the frame_start cycle: it would read a stale fetch address.
  assign grant_disp = !rst && !frame_start && (urgent || (eligible && !host_ok));
  assign grant_host = !rst && !urgent && host_ok;

  always_comb begin
    mem_en    = grant_disp || grant_host;
    mem_we    = grant_host && host_is_write;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_host) begin
      mem_addr = host_addr;
      if (host_is_write) begin
        mem_wdata = host_wdata;
      end
    end else if (grant_disp) begin
      mem_addr = fetch_addr_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      fetch_addr_reg    <= '0;
      disp_inflight_reg <= 1'b0;
      host_ack_reg      <= 1'b0;
      underflow_reg     <= 1'b0;
    end else begin
      host_ack_reg <= grant_host;
      if (frame_start) begin
        state_reg         <= FETCH;
        fetch_addr_reg    <= '0;
        disp_inflight_reg <= 1'b0;
        underflow_reg     <= 1'b0;
      end else begin
        disp_inflight_reg <= grant_disp;
        if (grant_disp) begin
          fetch_addr_reg <= fetch_addr_reg + ADDR_W'(1);
          if (fetch_addr_reg == LAST_ADDR) begin
            state_reg <= DONE;
          end
        end
        if (pix_re && !pix_valid) begin
          underflow_reg <= 1'b1;
        end
      end
    end
  end

`ifdef VGA_FB_HOST_READ_EN
  logic host_rd_inflight_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      host_rd_inflight_reg <= 1'b0;
    end else begin
      host_rd_inflight_reg <= grant_host && !host_we;
    end
  end

  assign host_is_write = host_we;
  assign host_rdata    = (host_ack_reg && host_rd_inflight_reg) ? mem_rdata : '0;
`else
  logic unused_host_we;

  assign unused_host_we = host_we;
  assign host_is_write  = 1'b1;
  assign host_rdata     = '0;
`endif

  // A display read issued last cycle lands now; frame_start discards it via flush.
  assign fifo_push = disp_inflight_reg && !frame_start;
  assign fifo_pop  = pix_re && !frame_start;

  vga_pixel_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (frame_start),
    .push      (fifo_push),
    .push_data (mem_rdata),
    .pop       (fifo_pop),
    .pop_data  (pix_data),
    .valid     (pix_valid),
    .count     (fifo_count)
  );

  assign host_ack  = host_ack_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter with a reduced frame and a behavioural RAM.
module tb_vga_fb_arbiter;

  localparam int H_ACT  = 64;
  localparam int V_ACT  = 16;
  localparam int FRAME  = H_ACT * V_ACT;
  localparam int AW     = 12;
  localparam int DW     = 8;
  localparam int MEM_SZ = 1 << AW;

`ifdef VGA_FB_HOST_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          pix_re = 1'b0;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          underflow;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  vga_fb_arbiter #(
    .H_ACTIVE   (H_ACT),
    .V_ACTIVE   (V_ACT),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (16),
    .FIFO_LOW   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pix_re      (pix_re),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .underflow   (underflow),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Physical RAM seen by the DUT, and the bench's own view of what it should hold.
  logic [DW-1:0] ram    [MEM_SZ];
  logic [DW-1:0] shadow [MEM_SZ];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  function automatic logic [DW-1:0] pat(input int a);
    return 8'((a * 37) + ((a >> 8) * 11) + 3);
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor: counts display reads (in-frame addresses) and all enables.
  int          disp_reads = 0;
  int          en_count = 0;
  int          last_disp = -1;
  int          disp_q[$];

  always begin
    @(negedge clk);
    #1;
    if (mem_en) en_count++;
    if (mem_en && !mem_we && (int'(mem_addr) < FRAME)) begin
      disp_reads++;
      disp_q.push_back(int'(mem_addr));
      last_disp = int'(mem_addr);
    end
  end

  task automatic host_xfer(input string name, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd, input int max_lat);
    logic eff_we;
    logic seen_grant;
    logic got;
    int   lat;
    eff_we     = READ_EN ? we : 1'b1;
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = addr;
    host_wdata = wd;
    seen_grant = 1'b0;
    got        = 1'b0;
    lat        = 0;
    while (1) begin
      #1;
      if (lat > 0 && host_ack) begin
        got = 1'b1;
        break;
      end
      if (!seen_grant && mem_en && mem_addr == addr) begin
        seen_grant = 1'b1;
        check({name, "_we"}, mem_we, eff_we);
        if (eff_we) check({name, "_wdata"}, mem_wdata, wd);
      end
      if (lat >= 10) break;
      @(negedge clk);
      lat++;
    end
    $display("txn %s we=%0b addr=%0h wd=%0h rd=%0h lat=%0d", name, eff_we, addr, wd, host_rdata, lat);
    check({name, "_ack"}, got, 1'b1);
    check({name, "_grant"}, seen_grant, 1'b1);
    check({name, "_lat_ok"}, (lat <= max_lat), 1'b1);
    if (!eff_we) check({name, "_rdata"}, host_rdata, exp_rd);
    host_req = 1'b0;
    if (eff_we) shadow[addr] = wd;
  endtask

  typedef struct {
    string         name;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    int            max_lat;
  } vec_t;

  vec_t vecs[7];
  bit   pop_done;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int bad;
    int n_en;
    int reads_done;

    for (int i = 0; i < MEM_SZ; i++) begin
      ram[i]    = pat(i);
      shadow[i] = pat(i);
    end

    vecs[0] = '{"wr5",     1'b1, AW'(5),    8'hA5, 8'h00, 1};
    vecs[1] = '{"rd5",     1'b0, AW'(5),    8'h00, READ_EN ? 8'hA5 : 8'h00, 1};
    vecs[2] = '{"rd100",   1'b0, AW'(100),  8'h00, READ_EN ? pat(100) : 8'h00, 1};
    vecs[3] = '{"wr4000",  1'b1, AW'(4000), 8'h3C, 8'h00, 1};
    vecs[4] = '{"rd4000",  1'b0, AW'(4000), 8'h00, READ_EN ? 8'h3C : 8'h00, 1};
    vecs[5] = '{"wrlast",  1'b1, AW'(FRAME - 1), 8'h7E, 8'h00, 1};
    vecs[6] = '{"rdtop",   1'b0, AW'(MEM_SZ - 1), 8'h00, READ_EN ? pat(MEM_SZ - 1) : 8'h00, 1};

    // Reset with a pending host request: everything quiet.
    host_req = 1'b1; host_we = 1'b1; host_addr = AW'(2000); host_wdata = 8'h11;
    repeat (3) @(negedge clk);
    #1;
    check("rst_outs", {mem_en, mem_we, mem_addr, mem_wdata, host_ack, host_rdata,
                       pix_valid, pix_data, underflow}, 64'd0);

    // Held request in IDLE: grant, ack, grant, ack...
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      host_we = (i < 4);
      #1;
      check("idle_en", mem_en, (i % 2 == 0));
      check("idle_ack", host_ack, (i % 2 == 1));
      if (i % 2 == 0) begin
        check("idle_we", mem_we, READ_EN ? host_we : 1'b1);
        check("idle_addr", mem_addr, AW'(2000));
      end
      @(negedge clk);
    end
    host_req = 1'b0;
    shadow[2000] = 8'h11;
    check("idle_no_disp", disp_reads, 0);
    @(negedge clk);

    // Table of single host transactions while no frame is running.
    foreach (vecs[i]) begin
      host_xfer(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rdata, vecs[i].max_lat);
      @(negedge clk);
    end

    // frame_start with no pops: exactly FIFO_DEPTH reads at 0..15.
    disp_reads = 0;
    disp_q.delete();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("fill_reads", disp_reads, 16);
    bad = 0;
    foreach (disp_q[i]) if (disp_q[i] != i) bad++;
    check("fill_order", bad, 0);
    check("fill_valid", pix_valid, 1'b1);
    check("fill_data", pix_data, shadow[0]);
    n_en = en_count;
    repeat (10) @(negedge clk);
    #1;
    check("fill_quiet", en_count, n_en);

    // Pop six, then restart the frame with a display read in flight.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pix_re = 1'b1;
      #1;
      check("flush_pop_valid", pix_valid, 1'b1);
      check("flush_pop_data", pix_data, shadow[i]);
    end
    @(negedge clk);
    pix_re = 1'b0;
    #1;
    check("flush_disp_grant", {mem_en, mem_we}, 2'b10);
    @(negedge clk);
    frame_start = 1'b1;
    #1;
    check("flush_no_grant", mem_en, 1'b0);
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    check("flush_empty", pix_valid, 1'b0);
    check("flush_restart", {mem_en, mem_we, mem_addr}, {2'b10, AW'(0)});
    repeat (2) @(negedge clk);
    #1;
    check("flush_first_valid", pix_valid, 1'b1);
    check("flush_first_data", pix_data, shadow[0]);

    // Full frame: pops at half rate plus random host traffic outside the frame.
    @(negedge clk);
    disp_reads = 0;
    last_disp = -1;
    pop_done = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    fork
      begin
        repeat (40) @(negedge clk);
        for (int k = 0; k < FRAME; k++) begin
          @(negedge clk);
          pix_re = 1'b1;
          #1;
          check("frame_valid", pix_valid, 1'b1);
          check("frame_data", pix_data, shadow[k]);
          @(negedge clk);
          pix_re = 1'b0;
        end
        pop_done = 1'b1;
      end
      begin
        repeat (40) @(negedge clk);
        while (!pop_done) begin
          logic          we;
          logic [AW-1:0] a;
          logic [DW-1:0] d;
          we = 1'($urandom_range(0, 1));
          a  = AW'($urandom_range(FRAME, MEM_SZ - 1));
          d  = 8'($urandom);
          host_xfer("rand", we, a, d, (READ_EN && !we) ? shadow[a] : 8'h00, 3);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    join
    #1;
    check("frame_underflow", underflow, 1'b0);
    check("frame_last_addr", last_disp, FRAME - 1);
    check("frame_reads", disp_reads, FRAME);
    reads_done = disp_reads;
    repeat (20) @(negedge clk);
    #1;
    check("frame_done_quiet", disp_reads, reads_done);

    // Underflow is sticky and cleared by the next frame_start.
    @(negedge clk);
    pix_re = 1'b1;
    #1;
    check("uf_empty", {pix_valid, pix_data}, 9'd0);
    @(negedge clk);
    pix_re = 1'b0;
    #1;
    check("uf_set", underflow, 1'b1);
    repeat (5) @(negedge clk);
    #1;
    check("uf_sticky", underflow, 1'b1);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    check("uf_cleared", underflow, 1'b0);
    check("uf_refetch", {mem_en, mem_we, mem_addr}, {2'b10, AW'(0)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
